// File: rtl/alu_pkg.sv
// Shared op encoding and status-flag type for the pipelined ALU.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  localparam int INV_BIT = 2;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (a, b, f) -> y and, with ALU_PIPE_FLAGS_EN, status flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] y
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output flags_t           flags
`endif
);

  logic [WIDTH-1:0] b_eff;
  logic             cin;

  assign b_eff = f[INV_BIT] ? ~b : b;
  assign cin   = f[INV_BIT];

  // Carry-out bit is only kept when flags are built.
`ifdef ALU_PIPE_FLAGS_EN
  logic [WIDTH:0] sum;
  assign sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
`else
  logic [WIDTH-1:0] sum;
  assign sum = a + b_eff + {{(WIDTH-1){1'b0}}, cin};
`endif

  always_comb begin
    y = '0;
    case (f[1:0])
      OP_AND:  y = a & b_eff;
      OP_OR:   y = a | b_eff;
      OP_ADD:  y = sum[WIDTH-1:0];
      OP_CMP:  y = {{(WIDTH-1){1'b0}}, f[INV_BIT] ? (a > b) : (a == b)};
      default: y = '0;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  logic is_add;
  assign is_add      = (f[1:0] == OP_ADD);
  assign flags.zero  = (y == '0);
  assign flags.carry = is_add & sum[WIDTH];
  assign flags.ovf   = is_add & (a[WIDTH-1] == b_eff[WIDTH-1]) & (y[WIDTH-1] != a[WIDTH-1]);
`endif

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline around alu_core.
// Define ALU_PIPE_FLAGS_EN to build the registered zero/carry/ovf flags; otherwise they are tied low.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int STAGES = 2;

  logic [STAGES:1]  vld_pipe;
  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] s1_a, s1_b, y_c;
  logic [2:0]       s1_f;

  // A stage may take a new beat when it is empty or its contents move on this cycle.
  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= in_valid;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
    end
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_a <= in_a;
      s1_b <= in_b;
      s1_f <= in_f;
    end
  end

`ifdef ALU_PIPE_FLAGS_EN
  flags_t flags_c, flags_q;
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (s1_a),
    .b     (s1_b),
    .f     (s1_f),
    .y     (y_c)
`ifdef ALU_PIPE_FLAGS_EN
    ,
    .flags (flags_c)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst)                        out_y <= '0;
    else if (s2_adv && vld_pipe[1]) out_y <= y_c;
  end

`ifdef ALU_PIPE_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst)                        flags_q <= '0;
    else if (s2_adv && vld_pipe[1]) flags_q <= flags_c;
  end

  assign out_zero  = flags_q.zero;
  assign out_carry = flags_q.carry;
  assign out_ovf   = flags_q.ovf;
`else
  assign out_zero  = 1'b0;
  assign out_carry = 1'b0;
  assign out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): directed ops/flags/compare, backpressure, throughput, reset flush.
module tb_alu_pipe;

  localparam int W = 8;
`ifdef ALU_PIPE_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid, out_zero, out_carry, out_ovf;
  logic [W-1:0] in_a = '0, in_b = '0, out_y;
  logic [2:0]   in_f = '0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_f(in_f),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero), .out_carry(out_carry), .out_ovf(out_ovf)
  );

  typedef struct {
    logic [W-1:0] y;
    logic         z, c, o;
    int           t;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_vec = 0, n_err = 0, n_out = 0, cyc = 0;
  int   run = 0, max_run = 0;
  bit   lat_chk = 1'b0, saw_low = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] y, input logic z, input logic c, input logic o);
    exp_t e;
    e.y = y; e.z = z & FL; e.c = c & FL; e.o = o & FL; e.t = 0;
    return e;
  endfunction

  // Reference: written per op, independent of the RTL's shared-adder form.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
    logic [W-1:0] y;
    logic [W:0]   s;
    logic         c, o;
    y = '0; c = 1'b0; o = 1'b0; s = '0;
    case (f)
      3'b000: y = a & b;
      3'b001: y = a | b;
      3'b100: y = a & ~b;
      3'b101: y = a | ~b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[W-1:0]; c = s[W];
        o = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
      end
      3'b110: begin
        y = a - b; c = (a >= b);
        o = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
      end
      3'b011: y = (a == b) ? 8'd1 : 8'd0;
      default: y = (a > b) ? 8'd1 : 8'd0;
    endcase
    return mk(y, (y == 0), c, o);
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: inputs change just after posedge, so at negedge both sides are stable for the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      run = 0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {31'b0, out_valid}, 32'd0);
        end else begin
          chk("y", {24'b0, out_y}, {24'b0, q[0].y});
          chk("zero", {31'b0, out_zero}, {31'b0, q[0].z});
          chk("carry", {31'b0, out_carry}, {31'b0, q[0].c});
          chk("ovf", {31'b0, out_ovf}, {31'b0, q[0].o});
          if (out_ready) begin
            if (lat_chk) chk("latency", cyc - q[0].t, 32'd2);
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (out_valid && out_ready) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (in_valid && in_ready) begin
        e = cur; e.t = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic tick(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready && !rst;
    if (!in_ready) saw_low = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f, input exp_t e);
    bit acc;
    int n;
    in_a = a; in_b = b; in_f = f; cur = e; in_valid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin tick(acc); n++; end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin tick(acc); n++; end
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f, input exp_t e);
    send(a, b, f, e);
    drain();
  endtask

  initial begin
    bit acc;
    int i, c, n0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_y", {24'b0, out_y}, 32'd0);
    chk("rst_flags", {29'b0, out_zero, out_carry, out_ovf}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed ops, flags and compares; each checked for 2-cycle latency.
    lat_chk = 1'b1;
    one(8'h5A, 8'h0F, 3'b000, mk(8'h0A, 0, 0, 0));
    one(8'h5A, 8'h0F, 3'b001, mk(8'h5F, 0, 0, 0));
    one(8'h5A, 8'h0F, 3'b100, mk(8'h50, 0, 0, 0));
    one(8'h5A, 8'h0F, 3'b101, mk(8'hFA, 0, 0, 0));
    one(8'hFF, 8'h01, 3'b010, mk(8'h00, 1, 1, 0));
    one(8'h7F, 8'h01, 3'b010, mk(8'h80, 0, 0, 1));
    one(8'h05, 8'h07, 3'b110, mk(8'hFE, 0, 0, 0));
    one(8'h80, 8'h01, 3'b110, mk(8'h7F, 0, 1, 1));
    one(8'h33, 8'h33, 3'b011, mk(8'h01, 0, 0, 0));
    one(8'h34, 8'h33, 3'b111, mk(8'h01, 0, 0, 0));
    one(8'h33, 8'h34, 3'b111, mk(8'h00, 1, 0, 0));
    lat_chk = 1'b0;

    // Backpressure: sink stalls for stream cycles 3..6.
    n0 = n_out; saw_low = 1'b0; i = 0; c = 0;
    while ((i < 6 || c < 8) && c < 60) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (i < 6);
      in_a = W'(i); in_b = 8'h01; in_f = 3'b010;
      cur = model(W'(i), 8'h01, 3'b010);
      tick(acc);
      if (acc) i++;
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    chk("bp_in_ready_low", {31'b0, saw_low}, 32'd1);
    chk("bp_count", n_out - n0, 32'd6);

    // Throughput: 16 back-to-back random beats.
    repeat (2) tick(acc);
    n0 = n_out; max_run = 0;
    for (int k = 0; k < 16; k++) begin
      in_a = W'($urandom); in_b = W'($urandom); in_f = 3'($urandom_range(0, 7));
      cur = model(in_a, in_b, in_f);
      in_valid = 1'b1;
      tick(acc);
      chk("tp_accept", {31'b0, acc}, 32'd1);
    end
    in_valid = 1'b0;
    drain();
    chk("tp_count", n_out - n0, 32'd16);
    chk("tp_run", max_run, 32'd16);

    // Reset with two beats held in flight; neither may ever appear.
    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'b010, model(8'h11, 8'h22, 3'b010));
    send(8'h21, 8'h03, 3'b001, model(8'h21, 8'h03, 3'b001));
    rst = 1'b1; in_valid = 1'b1; in_a = 8'h99; in_b = 8'h01; in_f = 3'b010;
    cur = model(8'h99, 8'h01, 3'b010);
    tick(acc);
    chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_out_y", {24'b0, out_y}, 32'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    n0 = n_out;
    repeat (6) tick(acc);
    chk("rst_mid_no_emit", n_out - n0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
